// File: rtl/if_pkg.sv
// Shared constants and types for the instruction fetch unit and its queues.
package if_pkg;

  localparam int          DEF_PC_W     = 32;
  localparam int          DEF_INSTR_W  = 32;
  localparam int          DEF_DEPTH    = 4;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam int          DEF_INC      = 4;

  typedef logic [DEF_PC_W-1:0] pc_t;

  typedef enum logic {
    REDIR_ABS = 1'b0,
    REDIR_REL = 1'b1
  } redir_mode_e;

endpackage

// File: rtl/if_fifo.sv
// Synchronous FIFO with flush; head is visible on dout_o whenever count_o != 0.
module if_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [W-1:0]           din_i,
  input  logic                   pop_i,
  output logic [W-1:0]           dout_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, wr_d, rd_q, rd_d;

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (flush_i) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (push_i) wr_d = wr_q + ONE;
      if (pop_i)  rd_d = rd_q + ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage needs no reset: nothing is read from it until a push has landed.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_q[AW-1:0]] <= din_i;
  end

  assign dout_o  = mem_q[rd_q[AW-1:0]];
  assign count_o = wr_q - rd_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// In-order instruction fetch: PC, credit-limited requests, prefetch queue, redirect with stale drop.
// Handshakes: a transfer happens in a cycle where valid & ready are both high; valid never waits on ready.
module instr_fetch_unit
  import if_pkg::*;
#(
  parameter int              PC_W     = DEF_PC_W,
  parameter int              INSTR_W  = DEF_INSTR_W,
  parameter int              DEPTH    = DEF_DEPTH,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEF_RESET_PC),
  parameter int              INC      = DEF_INC
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               redirect_valid,
  input  logic               redirect_rel,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic [PC_W-1:0]    redirect_target,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [PC_W-1:0]    imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int SUM_W = CNT_W + 1;
  localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(INC - 1);

  logic [PC_W-1:0]         fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0]        outst_q, outst_d;
  logic [CNT_W-1:0]        drop_q, drop_d;
  logic [CNT_W-1:0]        pq_count, tag_count;
  logic [PC_W-1:0]         tag_pc;
  logic [PC_W+INSTR_W-1:0] pq_head;
  logic [PC_W-1:0]         redir_pc;
  logic                    req_fire, rsp_in, rsp_keep, out_fire, pq_empty;

  // Credit covers stale in-flight fetches too, so the prefetch queue can never overflow.
  assign imem_req_valid = reset && !redirect_valid &&
                          (({1'b0, outst_q} + {1'b0, pq_count}) < SUM_W'(DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_in   = imem_rsp_valid && (outst_q != '0);
  assign rsp_keep = rsp_in && !redirect_valid && (drop_q == '0) && (tag_count != '0);

  assign pq_empty  = (pq_count == '0);
  assign out_valid = !pq_empty;
  assign out_fire  = out_valid && out_ready;
  assign out_pc    = pq_empty ? RESET_PC : pq_head[PC_W+INSTR_W-1:INSTR_W];
  assign out_instr = pq_empty ? '0 : pq_head[INSTR_W-1:0];

  assign redir_pc = ((redir_mode_e'(redirect_rel) == REDIR_REL) ?
                     (redirect_pc + redirect_target) : redirect_target) & ALIGN_MASK;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    drop_d     = drop_q;
    outst_d    = outst_q + CNT_W'(req_fire) - CNT_W'(rsp_in);
    if (redirect_valid) begin
      fetch_pc_d = redir_pc;
      // Everything still in flight after this cycle belongs to the abandoned stream.
      drop_d     = outst_q - CNT_W'(rsp_in);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + PC_W'(INC);
      if (rsp_in && (drop_q != '0)) drop_d = drop_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

  if_fifo #(.W(PC_W), .DEPTH(DEPTH)) u_tag_q (
    .clk     (clk),
    .rst_n   (reset),
    .flush_i (redirect_valid),
    .push_i  (req_fire),
    .din_i   (fetch_pc_q),
    .pop_i   (rsp_keep),
    .dout_o  (tag_pc),
    .count_o (tag_count)
  );

  if_fifo #(.W(PC_W + INSTR_W), .DEPTH(DEPTH)) u_prefetch_q (
    .clk     (clk),
    .rst_n   (reset),
    .flush_i (redirect_valid),
    .push_i  (rsp_keep),
    .din_i   ({tag_pc, imem_rsp_data}),
    .pop_i   (out_fire),
    .dout_o  (pq_head),
    .count_o (pq_count)
  );

endmodule
